// File: rtl/axi4_lite_read_slave_mem_if.sv
// AXI4-Lite read channel bundle (AR + R) shared by the read master and the
// read-only memory slave.
interface axi4_lite_read_slave_mem_if #(
   parameter int AW = 64
);
   logic [AW-1:0] AR_ADDR;
   logic          AR_VALID;
   logic [2:0]    AR_PROT;
   logic          AR_READY;
   logic [63:0]   R_DATA;
   logic [1:0]    R_RESP;
   logic          R_VALID;
   logic          R_READY;

   modport slave (
      input  AR_ADDR, AR_VALID, AR_PROT, R_READY,
      output AR_READY, R_DATA, R_RESP, R_VALID
   );

   modport master (
      output AR_ADDR, AR_VALID, AR_PROT, R_READY,
      input  AR_READY, R_DATA, R_RESP, R_VALID
   );
endinterface

// File: rtl/axi4_lite_read_slave_mem.sv
// AXI4-Lite read-only slave backed by a 64-bit word memory, one outstanding
// read, configurable wait states and a synchronous backdoor write port.
module axi4_lite_read_slave_mem #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int AW      = 64,
   localparam int IW     = $clog2(DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst,
   axi4_lite_read_slave_mem_if.slave           bus,
   input  logic                                wr_en,
   input  logic [IW-1:0]                       wr_idx,
   input  logic [63:0]                         wr_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_e        state_q, state_d;
   logic          ar_ready_q, ar_ready_d;
   logic          r_valid_q, r_valid_d;
   logic [63:0]   r_data_q, r_data_d;
   logic [1:0]    r_resp_q, r_resp_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          err_q, err_d;

   logic [63:0]   mem_q [DEPTH];

   logic [IW-1:0] addr_idx;
   logic          addr_err;
   logic [63:0]   rd_word;
   logic          unused_bits;

   assign addr_idx    = bus.AR_ADDR[IW+2:3];
   assign addr_err    = |bus.AR_ADDR[AW-1:IW+3];
   assign unused_bits = ^{bus.AR_PROT, bus.AR_ADDR[2:0]};

   // A backdoor write landing on the same edge the response is loaded must win.
   assign rd_word = (wr_en && (wr_idx == idx_q)) ? wr_data : mem_q[idx_q];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
      end
   end

   // Every handshake passes through WAIT (even with LATENCY=0) so that R_VALID
   // always rises LATENCY+1 edges after the address is accepted.
   always_comb begin
      state_d    = state_q;
      ar_ready_d = ar_ready_q;
      r_valid_d  = r_valid_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      err_d      = err_q;

      unique case (state_q)
         ST_IDLE: begin
            ar_ready_d = 1'b1;
            r_valid_d  = 1'b0;
            if (ar_ready_q && bus.AR_VALID) begin
               idx_d      = addr_idx;
               err_d      = addr_err;
               cnt_d      = 4'(LATENCY);
               ar_ready_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            ar_ready_d = 1'b0;
            if (cnt_q == '0) begin
               state_d   = ST_RESP;
               r_valid_d = 1'b1;
               r_data_d  = err_q ? 64'd0 : rd_word;
               r_resp_d  = err_q ? RESP_DECERR : RESP_OKAY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_RESP: begin
            ar_ready_d = 1'b0;
            r_valid_d  = 1'b1;
            if (bus.R_READY) begin
               r_valid_d  = 1'b0;
               ar_ready_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            ar_ready_d = 1'b0;
            r_valid_d  = 1'b0;
         end
      endcase
   end

   assign bus.AR_READY = ar_ready_q;
   assign bus.R_VALID  = r_valid_q;
   assign bus.R_DATA   = r_data_q;
   assign bus.R_RESP   = r_resp_q;

endmodule

// File: tb/tb_axi4_lite_read_slave_mem.sv
// Bench for axi4_lite_read_slave_mem: two instances (LATENCY=2 and LATENCY=0)
// share the backdoor port; one array model predicts every read response.
module tb_axi4_lite_read_slave_mem;

   logic        clk;
   logic        rst;
   logic [63:0] ar_addr;
   logic        ar_valid;
   logic [2:0]  ar_prot;
   logic        r_ready;
   logic        wr_en;
   logic [9:0]  wr_idx;
   logic [63:0] wr_data;
   bit          sel;

   logic        obs_ar_ready;
   logic        obs_r_valid;
   logic [63:0] obs_r_data;
   logic [1:0]  obs_r_resp;

   logic [63:0] model_mem [1024];
   int          n_checks;
   int          n_errors;

   axi4_lite_read_slave_mem_if #(.AW(64)) bus2 ();
   axi4_lite_read_slave_mem_if #(.AW(64)) bus0 ();

   assign bus2.AR_ADDR  = ar_addr;
   assign bus2.AR_PROT  = ar_prot;
   assign bus2.AR_VALID = ar_valid && !sel;
   assign bus2.R_READY  = r_ready && !sel;
   assign bus0.AR_ADDR  = ar_addr;
   assign bus0.AR_PROT  = ar_prot;
   assign bus0.AR_VALID = ar_valid && sel;
   assign bus0.R_READY  = r_ready && sel;

   assign obs_ar_ready = sel ? bus0.AR_READY : bus2.AR_READY;
   assign obs_r_valid  = sel ? bus0.R_VALID  : bus2.R_VALID;
   assign obs_r_data   = sel ? bus0.R_DATA   : bus2.R_DATA;
   assign obs_r_resp   = sel ? bus0.R_RESP   : bus2.R_RESP;

   axi4_lite_read_slave_mem #(.DEPTH(1024), .LATENCY(2), .AW(64)) dut_lat2 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus2),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
   );

   axi4_lite_read_slave_mem #(.DEPTH(1024), .LATENCY(0), .AW(64)) dut_lat0 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus0),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic backdoor(input logic [9:0] idx, input logic [63:0] val);
      wr_en   = 1'b1;
      wr_idx  = idx;
      wr_data = val;
      model_mem[idx] = val;
      tick();
      wr_en = 1'b0;
   endtask

   // One full read on the selected instance; the response is predicted from
   // the address rules and the model contents at the edge entering the response.
   task automatic applyStimulus(input logic [63:0] addr, input int ready_delay,
                                input bit wr_wait, input logic [63:0] wr_wait_val,
                                input bit wr_resp, input bit hold_ar);
      int          lat;
      logic [9:0]  idx;
      bit          err;
      logic [63:0] exp_data;
      logic [1:0]  exp_resp;
      logic [63:0] late_val;
      lat = sel ? 0 : 2;
      idx = addr[12:3];
      err = (addr[63:13] != 51'd0);

      ar_addr  = addr;
      ar_valid = 1'b1;
      ar_prot  = 3'($urandom);
      r_ready  = (ready_delay == 0);
      tick();
      checkOutput("ar_ready_after_hs", 64'(obs_ar_ready), 64'd0);
      checkOutput("r_valid_after_hs", 64'(obs_r_valid), 64'd0);
      if (!hold_ar) ar_valid = 1'b0;

      for (int i = 0; i < lat; i++) begin
         tick();
         checkOutput("r_valid_wait", 64'(obs_r_valid), 64'd0);
         checkOutput("ar_ready_wait", 64'(obs_ar_ready), 64'd0);
      end

      if (wr_wait) begin
         wr_en   = 1'b1;
         wr_idx  = idx;
         wr_data = wr_wait_val;
         model_mem[idx] = wr_wait_val;
      end
      exp_data = err ? 64'd0 : model_mem[idx];
      exp_resp = err ? 2'b11 : 2'b00;
      tick();
      wr_en = 1'b0;
      checkOutput("r_valid_rise", 64'(obs_r_valid), 64'd1);
      checkOutput("r_data", obs_r_data, exp_data);
      checkOutput("r_resp", 64'(obs_r_resp), 64'(exp_resp));
      checkOutput("ar_ready_resp", 64'(obs_ar_ready), 64'd0);

      for (int d = 0; d < ready_delay; d++) begin
         if (wr_resp && d == 0) begin
            late_val = ~exp_data ^ {$urandom, $urandom};
            wr_en    = 1'b1;
            wr_idx   = idx;
            wr_data  = late_val;
            model_mem[idx] = late_val;
         end
         tick();
         wr_en = 1'b0;
         checkOutput("r_valid_hold", 64'(obs_r_valid), 64'd1);
         checkOutput("r_data_hold", obs_r_data, exp_data);
         checkOutput("r_resp_hold", 64'(obs_r_resp), 64'(exp_resp));
         checkOutput("ar_ready_hold", 64'(obs_ar_ready), 64'd0);
      end

      ar_valid = 1'b0;
      r_ready  = 1'b1;
      tick();
      checkOutput("r_valid_done", 64'(obs_r_valid), 64'd0);
      checkOutput("ar_ready_done", 64'(obs_ar_ready), 64'd1);
      r_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] addr;
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      ar_addr  = '0;
      ar_valid = 1'b0;
      ar_prot  = '0;
      r_ready  = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = '0;
      wr_data  = '0;
      sel      = 1'b0;

      // Memory is loaded through the backdoor while reset is held.
      for (int i = 0; i < 1024; i++) begin
         wr_en   = 1'b1;
         wr_idx  = 10'(i);
         wr_data = {$urandom, $urandom};
         model_mem[i] = wr_data;
         tick();
         if (i < 3 || i == 1023) begin
            checkOutput("rst_ar_ready_l2", 64'(bus2.AR_READY), 64'd0);
            checkOutput("rst_r_valid_l2", 64'(bus2.R_VALID), 64'd0);
            checkOutput("rst_r_data_l2", bus2.R_DATA, 64'd0);
            checkOutput("rst_r_resp_l2", 64'(bus2.R_RESP), 64'd0);
            checkOutput("rst_ar_ready_l0", 64'(bus0.AR_READY), 64'd0);
            checkOutput("rst_r_valid_l0", 64'(bus0.R_VALID), 64'd0);
         end
      end
      wr_en = 1'b0;
      rst   = 1'b0;
      tick();
      checkOutput("idle_ar_ready_l2", 64'(bus2.AR_READY), 64'd1);
      checkOutput("idle_r_valid_l2", 64'(bus2.R_VALID), 64'd0);
      checkOutput("idle_ar_ready_l0", 64'(bus0.AR_READY), 64'd1);
      checkOutput("idle_r_valid_l0", 64'(bus0.R_VALID), 64'd0);

      $display("[TB] basic read and backpressure");
      backdoor(10'd5, 64'hDEAD_BEEF_0123_4567);
      applyStimulus(64'h28, 0, 1'b0, 64'd0, 1'b0, 1'b0);
      applyStimulus(64'h28, 5, 1'b0, 64'd0, 1'b1, 1'b1);

      $display("[TB] range boundary");
      applyStimulus(64'h2000, 1, 1'b0, 64'd0, 1'b0, 1'b0);
      applyStimulus(64'h1FFF, 0, 1'b0, 64'd0, 1'b0, 1'b0);
      applyStimulus(64'h8000_0000_0000_0010, 0, 1'b0, 64'd0, 1'b0, 1'b0);

      $display("[TB] write during wait");
      backdoor(10'd7, 64'hAAAA_5555_AAAA_5555);
      applyStimulus(64'h38, 0, 1'b1, 64'h1, 1'b0, 1'b0);
      sel = 1'b1;
      backdoor(10'd7, 64'hBBBB_CCCC_DDDD_EEEE);
      applyStimulus(64'h3B, 0, 1'b1, 64'h1, 1'b0, 1'b0);
      applyStimulus(64'h28, 2, 1'b0, 64'd0, 1'b1, 1'b1);
      sel = 1'b0;

      $display("[TB] reset during response");
      ar_addr  = 64'h50;
      ar_valid = 1'b1;
      r_ready  = 1'b0;
      tick();
      ar_valid = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("mid_r_valid", 64'(obs_r_valid), 64'd1);
      checkOutput("mid_r_data", obs_r_data, model_mem[10]);
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_r_valid", 64'(obs_r_valid), 64'd0);
      checkOutput("mid_rst_ar_ready", 64'(obs_ar_ready), 64'd0);
      checkOutput("mid_rst_r_data", obs_r_data, 64'd0);
      rst = 1'b0;
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      checkOutput("post_rst_ar_ready", 64'(obs_ar_ready), 64'd1);
      checkOutput("post_rst_r_valid", 64'(obs_r_valid), 64'd0);
      applyStimulus(64'h50, 1, 1'b0, 64'd0, 1'b0, 1'b0);

      $display("[TB] randomized reads");
      for (int t = 0; t < 40; t++) begin
         sel  = 1'($urandom_range(1, 0));
         addr = {51'd0, 13'($urandom)};
         if ($urandom_range(4, 0) == 0) addr = addr | (64'd1 << $urandom_range(63, 13));
         applyStimulus(addr, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                       {$urandom, $urandom}, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
